cv32e40p_fetch_aligner: RTL and testbench

//  Sits directly downstream of cv32e40p_prefetch_buffer and consumes its word-aligned 32-bit fetch stream.
//  Re-aligns that stream into whole RV32IC instructions (16- or 32-bit, possibly spanning two words) for the decoder.

---
 rtl/cv32e40p_fetch_aligner_pkg.sv | 20 ++
 rtl/cv32e40p_fetch_aligner_stats.sv | 38 +++
 rtl/cv32e40p_fetch_aligner.sv | 159 +++++++++++++++
 tb/tb_cv32e40p_fetch_aligner.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_fetch_aligner_pkg.sv
// Shared types and constants for the fetch aligner: state encoding, opcode marker
// for full-width instructions and PC increments.
package cv32e40p_fetch_aligner_pkg;

  typedef enum logic [1:0] {
    ALIGNED = 2'd0,
    MIS16   = 2'd1,
    BRMIS   = 2'd2
  } align_state_e;

  localparam logic [1:0]  OPC_FULL = 2'b11;
  localparam logic [31:0] PC_INC_C = 32'd2;
  localparam logic [31:0] PC_INC_I = 32'd4;

  // An RVC instruction is any halfword whose two low bits are not 2'b11.
  function automatic logic is_compressed(input logic [1:0] opc);
    return (opc != OPC_FULL);
  endfunction

endpackage

// File: rtl/cv32e40p_fetch_aligner_stats.sv
// Saturating counter of spanning 32-bit instructions. The module only exists when
// FETCH_ALIGNER_STATS_EN is defined.
`ifdef FETCH_ALIGNER_STATS_EN
module cv32e40p_fetch_aligner_stats #(
  parameter int unsigned STATS_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc_i,
  output logic [STATS_W-1:0] cnt_o
);

  logic [STATS_W-1:0] cnt_q;
  logic [STATS_W-1:0] cnt_d;

  // Next count: increment unless already at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {STATS_W{1'b1}})) begin
      cnt_d = cnt_q + {{(STATS_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {STATS_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/cv32e40p_fetch_aligner.sv
// Re-aligns the word-aligned prefetch stream into whole RV32IC instructions with PC.
// Optional misalign statistics counter under FETCH_ALIGNER_STATS_EN.
module cv32e40p_fetch_aligner
  import cv32e40p_fetch_aligner_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080,
  parameter int unsigned STATS_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  output logic        fetch_ready_o,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic        instr_compressed_o,
  output logic [31:0] pc_o
`ifdef FETCH_ALIGNER_STATS_EN
  ,
  output logic [STATS_W-1:0] misalign_cnt_o
`endif
);

  if (STATS_W < 1) begin : g_stats_w_range
    $error("STATS_W must be at least 1");
  end

  align_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [15:0]  residue_q, residue_d;
  logic         span_xfer_s;
  logic         br_addr_lsb_unused;

  assign br_addr_lsb_unused = branch_addr_i[0];

  // Output mux and next-state; a branch overrides every handshake.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    residue_d     = residue_q;
    instr_valid_o = 1'b0;
    fetch_ready_o = 1'b0;
    instr_o       = 32'h0000_0000;
    span_xfer_s   = 1'b0;
    if (branch_i) begin
      pc_d      = {branch_addr_i[31:1], 1'b0};
      state_d   = branch_addr_i[1] ? BRMIS : ALIGNED;
      residue_d = 16'h0000;
    end else begin
      case (state_q)
        ALIGNED: begin
          instr_valid_o = fetch_valid_i;
          if (is_compressed(fetch_rdata_i[1:0])) begin
            instr_o = {16'h0000, fetch_rdata_i[15:0]};
            if (fetch_valid_i && instr_ready_i) begin
              fetch_ready_o = 1'b1;
              residue_d     = fetch_rdata_i[31:16];
              pc_d          = pc_q + PC_INC_C;
              state_d       = MIS16;
            end else begin
              fetch_ready_o = 1'b0;
            end
          end else begin
            instr_o = fetch_rdata_i;
            if (fetch_valid_i && instr_ready_i) begin
              fetch_ready_o = 1'b1;
              pc_d          = pc_q + PC_INC_I;
            end else begin
              fetch_ready_o = 1'b0;
            end
          end
        end
        MIS16: begin
          if (is_compressed(residue_q[1:0])) begin
            // Residue alone is a full instruction: no new word is needed.
            instr_valid_o = 1'b1;
            instr_o       = {16'h0000, residue_q};
            if (instr_ready_i) begin
              pc_d    = pc_q + PC_INC_C;
              state_d = ALIGNED;
            end else begin
              pc_d = pc_q;
            end
          end else begin
            instr_valid_o = fetch_valid_i;
            instr_o       = {fetch_rdata_i[15:0], residue_q};
            if (fetch_valid_i && instr_ready_i) begin
              fetch_ready_o = 1'b1;
              residue_d     = fetch_rdata_i[31:16];
              pc_d          = pc_q + PC_INC_I;
              span_xfer_s   = 1'b1;
            end else begin
              fetch_ready_o = 1'b0;
            end
          end
        end
        BRMIS: begin
          if (is_compressed(fetch_rdata_i[17:16])) begin
            instr_valid_o = fetch_valid_i;
            instr_o       = {16'h0000, fetch_rdata_i[31:16]};
            if (fetch_valid_i && instr_ready_i) begin
              fetch_ready_o = 1'b1;
              pc_d          = pc_q + PC_INC_C;
              state_d       = ALIGNED;
            end else begin
              fetch_ready_o = 1'b0;
            end
          end else begin
            // Upper half starts a 32-bit instr: swallow the word into the residue.
            fetch_ready_o = fetch_valid_i;
            if (fetch_valid_i) begin
              residue_d = fetch_rdata_i[31:16];
              state_d   = MIS16;
            end else begin
              residue_d = residue_q;
            end
          end
        end
        default: begin
          state_d = ALIGNED;
        end
      endcase
    end
  end

  assign instr_compressed_o = is_compressed(instr_o[1:0]);
  assign pc_o               = pc_q;

  // State, PC and residue registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ALIGNED;
      pc_q      <= {BOOT_ADDR[31:1], 1'b0};
      residue_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      residue_q <= residue_d;
    end
  end

`ifdef FETCH_ALIGNER_STATS_EN
  cv32e40p_fetch_aligner_stats #(
    .STATS_W (STATS_W)
  ) u_stats (
    .clk   (clk),
    .rst   (rst),
    .inc_i (span_xfer_s),
    .cnt_o (misalign_cnt_o)
  );
`else
  logic span_xfer_unused;
  assign span_xfer_unused = span_xfer_s;
`endif

endmodule

// File: tb/tb_cv32e40p_fetch_aligner.sv
// Bench for cv32e40p_fetch_aligner: a memory image plus a halfword-level model of
// program order predicts every instruction, PC and handshake.
module tb_cv32e40p_fetch_aligner;

  localparam logic [31:0] BOOT = 32'h0000_0080;

  logic        clk;
  logic        rst;
  logic        fetch_valid_i;
  logic [31:0] fetch_rdata_i;
  logic        fetch_ready_o;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic        instr_compressed_o;
  logic [31:0] pc_o;
`ifdef FETCH_ALIGNER_STATS_EN
  logic [15:0] misalign_cnt_o;
`endif

  cv32e40p_fetch_aligner #(
    .BOOT_ADDR (BOOT),
    .STATS_W   (16)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .fetch_valid_i      (fetch_valid_i),
    .fetch_rdata_i      (fetch_rdata_i),
    .fetch_ready_o      (fetch_ready_o),
    .branch_i           (branch_i),
    .branch_addr_i      (branch_addr_i),
    .instr_valid_o      (instr_valid_o),
    .instr_ready_i      (instr_ready_i),
    .instr_o            (instr_o),
    .instr_compressed_o (instr_compressed_o),
    .pc_o               (pc_o)
`ifdef FETCH_ALIGNER_STATS_EN
    ,
    .misalign_cnt_o     (misalign_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mem [64];
  logic [31:0] pc_m;        // PC of the next instruction in program order
  logic [31:0] fa_m;        // address of the word the prefetcher presents next
  int          cnt_m;
  logic        obs_valid, obs_ready;
  logic [31:0] obs_instr, obs_pc;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[7:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // One clock: drive at negedge, compare against the program-order model, advance it.
  task automatic step(input logic r, input logic br, input logic [31:0] ba,
                      input logic fv, input logic rdy);
    logic [15:0] h0;
    logic        comp, exp_v, exp_r;
    logic [31:0] exp_i;
    int          len, d;
    @(negedge clk);
    rst           = r;
    branch_i      = br;
    branch_addr_i = ba;
    fetch_valid_i = fv;
    instr_ready_i = rdy;
    fetch_rdata_i = fv ? mem[fa_m[7:2]] : $urandom;
    #1;
    obs_valid = instr_valid_o;
    obs_ready = fetch_ready_o;
    obs_instr = instr_o;
    obs_pc    = pc_o;
    h0    = hw_at(pc_m);
    comp  = (h0[1:0] != 2'b11);
    len   = comp ? 2 : 4;
    exp_i = comp ? {16'h0000, h0} : {hw_at(pc_m + 32'd2), h0};
    d     = int'(fa_m - pc_m);      // bytes already fetched beyond pc (may be -2)
    exp_v = ((d + (fv ? 4 : 0)) >= len);
    exp_r = fv && (exp_v ? (rdy && (d < len)) : 1'b1);
    if (!r) begin
`ifdef FETCH_ALIGNER_STATS_EN
      chk_eq("misalign_cnt", {16'h0000, misalign_cnt_o}, cnt_m);
`endif
      if (br) begin
        chk_eq("br_valid", {31'd0, obs_valid}, 32'd0);
        chk_eq("br_ready", {31'd0, obs_ready}, 32'd0);
      end else begin
        chk_eq("valid", {31'd0, obs_valid}, {31'd0, exp_v});
        chk_eq("ready", {31'd0, obs_ready}, {31'd0, exp_r});
        if (exp_v) begin
          chk_eq("pc", obs_pc, pc_m);
          chk_eq("instr", obs_instr, exp_i);
          chk_eq("compressed", {31'd0, instr_compressed_o}, {31'd0, comp});
        end
      end
    end
    if (r) begin
      pc_m  = BOOT;
      fa_m  = BOOT;
      cnt_m = 0;
    end else if (br) begin
      pc_m = {ba[31:1], 1'b0};
      fa_m = {ba[31:2], 2'b00};
    end else begin
      if (exp_v && rdy) begin
        if (!comp && pc_m[1]) cnt_m++;
        pc_m = pc_m + len;
      end
      if (exp_r) fa_m = fa_m + 32'd4;
    end
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; branch_i = 1'b0; branch_addr_i = 32'h0; fetch_valid_i = 1'b0;
    fetch_rdata_i = 32'h0; instr_ready_i = 1'b0;
    pc_m = BOOT; fa_m = BOOT; cnt_m = 0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;

    // Reset state, then two aligned 32-bit instructions
    mem[32] = 32'h0000_0013; mem[33] = 32'h0010_0093;
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk_eq("rst_valid", {31'd0, obs_valid}, 32'd0);
    chk_eq("rst_ready", {31'd0, obs_ready}, 32'd0);
    chk_eq("rst_pc", obs_pc, 32'h0000_0080);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk_eq("t1_i0", obs_instr, 32'h0000_0013);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk_eq("t1_pc1", obs_pc, 32'h0000_0084);
    chk_eq("t1_i1", obs_instr, 32'h0010_0093);

    // c.nop followed by a spanning 32-bit instruction
    mem[32] = 32'h0013_0001; mem[33] = 32'h0000_0000;
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk_eq("t2_cnop", obs_instr, 32'h0000_0001);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk_eq("t2_span_pc", obs_pc, 32'h0000_0082);
    chk_eq("t2_span_i", obs_instr, 32'h0000_0013);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Two c.nops in one word: second needs no fetch
    mem[32] = 32'h0001_0001;
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk_eq("t3_ready0", {31'd0, obs_ready}, 32'd1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk_eq("t3_valid1", {31'd0, obs_valid}, 32'd1);
    chk_eq("t3_pc1", obs_pc, 32'h0000_0082);

    // Branch to a misaligned target
    mem[0] = 32'h0001_ABCD;
    step(1'b0, 1'b1, 32'h0000_0102, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk_eq("t4_instr", obs_instr, 32'h0000_0001);
    chk_eq("t4_pc", obs_pc, 32'h0000_0102);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk_eq("t4_pc_next", obs_pc, 32'h0000_0104);

    // Decoder stall, then a branch mid-stall
    mem[32] = 32'h0000_0013;
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_eq("t5_stall_pc", obs_pc, 32'h0000_0080);
    end
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk_eq("t5_br_pc", obs_pc, 32'h0000_0200);

    // Reset while in MIS16 with a compressed residue pending
    mem[32] = 32'h0001_0001;
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0300, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk_eq("t6_rst_valid", {31'd0, obs_valid}, 32'd0);
    chk_eq("t6_rst_pc", obs_pc, 32'h0000_0080);

    // PC wrap
    mem[63] = 32'h0000_0013;
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk_eq("t6_wrap_pc", obs_pc, 32'h0000_0000);

    // Random program image, handshakes, branches and resets
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(199) == 0), ($urandom_range(19) == 0),
           ($urandom & 32'hFFFF_FFFE), ($urandom_range(9) < 7), ($urandom_range(9) < 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
